// File: rtl/regfile_mp_pkg.sv
// Shared types and helpers for the multi-port register file.
// The slice helper extracts field idx of width w from a flattened bus.
package regfile_pkg;

    typedef enum logic [0:0] {
        INIT = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int DEF_DATA_W = 32;
    localparam int DEF_ADDR_W = 5;
    localparam int DEF_NUM_RD = 2;

    // Widest supported buses: 4 ports x 64-bit fields.
    localparam int MAX_FIELD_W = 64;
    localparam int MAX_BUS_W   = 4 * MAX_FIELD_W;

    function automatic logic [MAX_FIELD_W-1:0] slice_field(
        input logic [MAX_BUS_W-1:0] bus,
        input int                   idx,
        input int                   w
    );
        logic [MAX_BUS_W-1:0]   sh;
        logic [MAX_FIELD_W-1:0] mask;
        sh   = bus >> (idx * w);
        mask = (MAX_FIELD_W'(1) << w) - MAX_FIELD_W'(1);
        return sh[MAX_FIELD_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/regfile_mp_if.sv
// Access bus of the register file: one write port, NUM_RD read ports, status.
interface regfile_mp_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int NUM_RD = 2
);
    logic                     WriteEnable;
    logic [ADDR_W-1:0]        RegWrite;
    logic [DATA_W-1:0]        DataWrite;
    logic [NUM_RD*ADDR_W-1:0] RegRead;
    logic [NUM_RD*DATA_W-1:0] ReadOut;
    logic                     Ready;
    logic                     WriteDropped;

    modport master (
        output WriteEnable, RegWrite, DataWrite, RegRead,
        input  ReadOut, Ready, WriteDropped
    );

    modport slave (
        input  WriteEnable, RegWrite, DataWrite, RegRead,
        output ReadOut, Ready, WriteDropped
    );
endinterface

// File: rtl/regfile_mp.sv
// Multi-read-port register file with sequential post-reset clear, optional
// hardwired zero entry and optional same-edge write-to-read bypass.
module regfile_mp
    import regfile_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_RD   = DEF_NUM_RD,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic          CLOCK,
    input  logic          RESET,
    regfile_mp_if.slave   bus
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] r_mem [DEPTH];
    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_clr_cnt;
    logic              r_ready;
    logic              r_drop;

    logic              w_mem_we;
    logic [ADDR_W-1:0] w_mem_addr;
    logic [DATA_W-1:0] w_mem_data;
    logic              w_drop_set;
    logic              w_wr_run;
    logic              w_wr_zero;

    assign w_wr_zero = (ZERO_REG != 0) && (bus.RegWrite == '0);

    // The clear sequencer and the user write share the single array write port.
    always_comb begin
        w_state_next = r_state;
        w_mem_we     = 1'b0;
        w_mem_addr   = bus.RegWrite;
        w_mem_data   = bus.DataWrite;
        w_drop_set   = 1'b0;
        w_wr_run     = 1'b0;
        case (r_state)
            INIT: begin
                w_mem_we   = 1'b1;
                w_mem_addr = r_clr_cnt;
                w_mem_data = '0;
                w_drop_set = bus.WriteEnable;
                if (&r_clr_cnt) begin
                    w_state_next = RUN;
                end
            end
            RUN: begin
                w_wr_run = bus.WriteEnable && !w_wr_zero;
                w_mem_we = w_wr_run;
            end
            default: begin
                w_state_next = INIT;
            end
        endcase
        if (RESET) begin
            w_state_next = INIT;
            w_mem_we     = 1'b0;
            w_drop_set   = 1'b0;
            w_wr_run     = 1'b0;
        end
    end

    always_ff @(posedge CLOCK) begin
        if (RESET) begin
            r_state   <= INIT;
            r_clr_cnt <= '0;
            r_ready   <= 1'b0;
            r_drop    <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_ready <= (w_state_next == RUN);
            if (r_state == INIT) begin
                r_clr_cnt <= r_clr_cnt + 1'b1;
            end
            if (w_drop_set) begin
                r_drop <= 1'b1;
            end
        end
    end

    // No reset on the storage itself so it stays mappable to block RAM.
    always_ff @(posedge CLOCK) begin
        if (w_mem_we) begin
            r_mem[w_mem_addr] <= w_mem_data;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] w_raddr;
            logic [DATA_W-1:0] r_rd;

            assign w_raddr = ADDR_W'(slice_field(MAX_BUS_W'(bus.RegRead), gi, ADDR_W));

            always_ff @(posedge CLOCK) begin
                if (RESET || (r_state != RUN)) begin
                    r_rd <= '0;
                end else if ((ZERO_REG != 0) && (w_raddr == '0)) begin
                    r_rd <= '0;
                end else if ((BYPASS != 0) && w_wr_run && (w_raddr == bus.RegWrite)) begin
                    r_rd <= bus.DataWrite;
                end else begin
                    r_rd <= r_mem[w_raddr];
                end
            end

            assign bus.ReadOut[gi*DATA_W +: DATA_W] = r_rd;
        end
    endgenerate

    assign bus.Ready        = r_ready;
    assign bus.WriteDropped = r_drop;

endmodule

// File: tb/tb_regfile_mp.sv
// Randomized bench for three register file configurations driven in lockstep
// and checked against a behavioural model of the access rules.
module tb_regfile_mp;

    localparam int NDUT = 3;
    localparam int DW [NDUT] = '{32, 32, 16};
    localparam int AW [NDUT] = '{5, 5, 4};
    localparam int NR [NDUT] = '{2, 2, 4};
    localparam int ZR [NDUT] = '{1, 0, 1};
    localparam int BP [NDUT] = '{1, 0, 1};

    logic        clk;
    logic        rst;
    logic        we;
    logic [4:0]  waddr;
    logic [31:0] wdata;
    logic [4:0]  raddr [4];

    int n_checks;
    int n_fail;

    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifa ();
    regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifb ();
    regfile_mp_if #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4)) ifc ();

    assign ifa.WriteEnable = we;
    assign ifa.RegWrite    = waddr;
    assign ifa.DataWrite   = wdata;
    assign ifa.RegRead     = {raddr[1], raddr[0]};
    assign ifb.WriteEnable = we;
    assign ifb.RegWrite    = waddr;
    assign ifb.DataWrite   = wdata;
    assign ifb.RegRead     = {raddr[1], raddr[0]};
    assign ifc.WriteEnable = we;
    assign ifc.RegWrite    = waddr[3:0];
    assign ifc.DataWrite   = wdata[15:0];
    assign ifc.RegRead     = {raddr[3][3:0], raddr[2][3:0], raddr[1][3:0], raddr[0][3:0]};

    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1), .BYPASS(1)) dut_a (
        .CLOCK(clk), .RESET(rst), .bus(ifa)
    );
    regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(0), .BYPASS(0)) dut_b (
        .CLOCK(clk), .RESET(rst), .bus(ifb)
    );
    regfile_mp #(.DATA_W(16), .ADDR_W(4), .NUM_RD(4), .ZERO_REG(1), .BYPASS(1)) dut_c (
        .CLOCK(clk), .RESET(rst), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [31:0] m_mem   [NDUT][32];
    int          m_edges [NDUT];
    bit          m_ready [NDUT];
    bit          m_drop  [NDUT];
    logic [31:0] m_rd    [NDUT][4];

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] obs_rd(input int k, input int p);
        case (k)
            0:       return ifa.ReadOut[p*32 +: 32];
            1:       return ifb.ReadOut[p*32 +: 32];
            default: return {16'h0, ifc.ReadOut[p*16 +: 16]};
        endcase
    endfunction

    function automatic bit obs_ready(input int k);
        case (k)
            0:       return ifa.Ready;
            1:       return ifb.Ready;
            default: return ifc.Ready;
        endcase
    endfunction

    function automatic bit obs_drop(input int k);
        case (k)
            0:       return ifa.WriteDropped;
            1:       return ifb.WriteDropped;
            default: return ifc.WriteDropped;
        endcase
    endfunction

    // Advance the model by one rising edge using the currently applied inputs.
    task automatic model_edge();
        for (int k = 0; k < NDUT; k++) begin
            logic [31:0] dmask;
            int          depth;
            int          wa;
            logic [31:0] wd;
            bit          wr_ok;
            dmask = (DW[k] == 32) ? 32'hFFFF_FFFF : ((32'd1 << DW[k]) - 32'd1);
            depth = 1 << AW[k];
            wa    = int'(waddr) % depth;
            wd    = wdata & dmask;
            if (rst) begin
                m_edges[k] = 0;
                m_ready[k] = 0;
                m_drop[k]  = 0;
                for (int p = 0; p < 4; p++) m_rd[k][p] = 0;
            end else if (!m_ready[k]) begin
                if (we) m_drop[k] = 1;
                m_edges[k]++;
                for (int p = 0; p < 4; p++) m_rd[k][p] = 0;
                if (m_edges[k] == depth) begin
                    m_ready[k] = 1;
                    for (int i = 0; i < 32; i++) m_mem[k][i] = 0;
                end
            end else begin
                wr_ok = we && !(ZR[k] != 0 && wa == 0);
                for (int p = 0; p < NR[k]; p++) begin
                    int ra;
                    ra = int'(raddr[p]) % depth;
                    if (ZR[k] != 0 && ra == 0)            m_rd[k][p] = 0;
                    else if (BP[k] != 0 && wr_ok && ra == wa) m_rd[k][p] = wd;
                    else                                   m_rd[k][p] = m_mem[k][ra];
                end
                if (wr_ok) m_mem[k][wa] = wd;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check_eq($sformatf("ready_k%0d", k), 64'(obs_ready(k)), 64'(m_ready[k]));
            check_eq($sformatf("drop_k%0d", k), 64'(obs_drop(k)), 64'(m_drop[k]));
            for (int p = 0; p < NR[k]; p++) begin
                check_eq($sformatf("rd_k%0d_p%0d", k, p), 64'(obs_rd(k, p)), 64'(m_rd[k][p]));
            end
        end
    endtask

    task automatic set_reads(input logic [4:0] a);
        for (int p = 0; p < 4; p++) raddr[p] = a;
    endtask

    // Run from the current state until port A reports Ready; returns edge count.
    task automatic run_to_ready(output int n, input int pulse_at);
        n = 0;
        while (!ifa.Ready && n < 100) begin
            if (n == pulse_at) begin
                we    = 1'b1;
                waddr = 5'd3;
                wdata = 32'hA5A5_A5A5;
            end else begin
                we = 1'b0;
            end
            step();
            n++;
        end
        we = 1'b0;
    endtask

    initial begin
        int n;
        n_checks = 0;
        n_fail   = 0;
        rst   = 1'b1;
        we    = 1'b0;
        waddr = '0;
        wdata = '0;
        set_reads(5'd0);
        for (int k = 0; k < NDUT; k++) begin
            m_edges[k] = 0;
            m_ready[k] = 0;
            m_drop[k]  = 0;
        end

        #2;
        step();
        step();

        // Abort the clear partway, then restart it.
        rst = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        run_to_ready(n, -1);
        check_eq("init_len_after_rereset", 64'(n), 64'd32);
        $display("INIT complete after %0d edges", n);

        for (int a = 1; a < 32; a++) begin
            set_reads(5'(a));
            step();
        end

        // Write then read on both ports.
        we = 1'b1; waddr = 5'd5; wdata = 32'hDEAD_BEEF; set_reads(5'd1);
        step();
        we = 1'b0; set_reads(5'd5);
        step();
        check_eq("rd_r5_a_p1", 64'(ifa.ReadOut[63:32]), 64'h0000_0000_DEAD_BEEF);

        // Same-edge write and read of r7.
        we = 1'b1; waddr = 5'd7; wdata = 32'h1234_5678; set_reads(5'd7);
        step();
        check_eq("bypass_a", 64'(ifa.ReadOut[31:0]), 64'h1234_5678);
        check_eq("nobypass_b", 64'(ifb.ReadOut[31:0]), 64'h0);

        // Write to r0 with a bypass-cycle read, then a plain read.
        we = 1'b1; waddr = 5'd0; wdata = 32'hFFFF_FFFF; set_reads(5'd0);
        step();
        we = 1'b0;
        step();
        check_eq("zero_reg_a", 64'(ifa.ReadOut[31:0]), 64'h0);
        check_eq("plain_r0_b", 64'(ifb.ReadOut[31:0]), 64'hFFFF_FFFF);
        check_eq("no_drop_a", 64'(ifa.WriteDropped), 64'd0);
        $display("directed accesses done");

        // Randomized traffic, biased toward read/write address collisions.
        for (int i = 0; i < 500; i++) begin
            we    = 1'($urandom_range(0, 1));
            waddr = 5'($urandom_range(0, 31));
            wdata = $urandom;
            for (int p = 0; p < 4; p++) begin
                raddr[p] = ($urandom_range(0, 3) == 0) ? waddr : 5'($urandom_range(0, 31));
            end
            step();
        end
        $display("random traffic done");

        // Write during the clear is dropped and flagged.
        rst = 1'b1; we = 1'b0;
        step();
        rst = 1'b0;
        run_to_ready(n, 5);
        check_eq("init_len_with_drop", 64'(n), 64'd32);
        check_eq("drop_sticky_a", 64'(ifa.WriteDropped), 64'd1);
        set_reads(5'd3);
        step();
        check_eq("r3_cleared_a", 64'(ifa.ReadOut[31:0]), 64'h0);
        step();
        $display("dropped write check done");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
